swervolf_ram_arbiter: RTL and testbench
=======================================

# swervolf_ram_arbiter

Two-master AXI4 arbiter that shares the single on-chip RAM slave (`axi_mem_wrapper`, 64-bit data) between the SweRV core RAM port (master 0) and a second bus master such as a DMA or debug loader (master 1). It sits between `swervolf_core`'s `o_ram_*` port and the RAM. Read and write channels are arbitrated independently with round-robin fairness. Each channel allows one outstanding transaction, held until its response completes.

## Interface
Parameters:
- `ID_WIDTH`, 4: AXI ID width, identical on both masters and the slave.
- `ADDR_WIDTH`, 32: address width.

Ports (`mN` = `m0`, `m1`; `s` = RAM slave):
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_mN_awid/awaddr/awlen/awsize/awburst/awvalid`, `o_mN_awready`  in/out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/1  master write address.
- `i_mN_wdata/wstrb/wlast/wvalid`, `o_mN_wready`  in/out  64/8/1/1/1  master write data.
- `o_mN_bid/bresp/bvalid`, `i_mN_bready`  out/in  ID_WIDTH/2/1/1  master write response.
- `i_mN_arid/araddr/arlen/arsize/arburst/arvalid`, `o_mN_arready`  in/out  as AW  master read address.
- `o_mN_rid/rdata/rresp/rlast/rvalid`, `i_mN_rready`  out/in  ID_WIDTH/64/2/1/1/1  master read data.
- `o_s_aw*`, `o_s_w*`, `i_s_b*`, `o_s_ar*`, `i_s_r*`  mirror of one master port with directions reversed, towards the RAM.

## Operation
- Write FSM states:
  - `W_IDLE`: if any `awvalid`, pick a winner and go to `W_ADDR`.
  - `W_ADDR`: forward the winner's AW. On the slave AW handshake, go to `W_DATA`.
  - `W_DATA`: forward the winner's W. On a handshake with `wlast=1`, go to `W_RESP`.
  - `W_RESP`: forward B to the winner. On the B handshake, go to `W_IDLE`.
- Read FSM states:
  - `R_IDLE`: if any `arvalid`, pick a winner and go to `R_ADDR`.
  - `R_ADDR`: forward AR. On the slave AR handshake, go to `R_DATA`.
  - `R_DATA`: forward R to the winner. On a handshake with `rlast=1`, go to `R_IDLE`.
- Round-robin per channel:
  - A 1-bit last-grant register, reset to 1, so m0 wins the first tie.
  - Simultaneous requests grant the master not granted last.
  - A single requester always wins.
  - The last-grant register updates when a winner is selected.
- Muxing:
  - The non-granted master sees `awready/wready/arready=0` and `bvalid/rvalid=0`.
  - Slave `valid` signals are 0 outside their forwarding state.
  - Slave `bready/rready` come from the granted master only in `W_RESP`/`R_DATA`.
- IDs pass through unchanged. Responses are routed by the registered grant, not by ID.
- W beats are accepted only in `W_DATA`. A master presenting W before AW is granted stalls with `wready=0`.
- Read and write FSMs are fully independent. m0 reading while m1 writes proceeds concurrently.

## Timing
- Reset (asynchronous assert): both FSMs go to IDLE, last-grant goes to 1, and every `valid`/`ready` output is 0. In-flight transactions are abandoned; the RAM shares the reset.
- Arbitration latency: the cycle a request is first seen in IDLE only registers the winner. The slave `awvalid/arvalid` asserts on the next cycle. This adds 1 cycle of address latency, with no combinational valid→ready path through arbitration.
- In W_ADDR/W_DATA/W_RESP/R_ADDR/R_DATA, `ready`/`valid` pass through combinationally. There are zero bubbles within a burst.
- Return to IDLE happens on the final handshake cycle. A new grant can be registered the following cycle, so the turnaround gap is ≥1 cycle between transactions on a channel.
- A burst `awlen/arlen` of 0..255 is not counted by the arbiter. Termination is by `wlast`/`rlast` only.
- A request deasserted while waiting in IDLE is a protocol violation. Once granted, AW/AR is held by AXI rules.

## Structure
- Package `swervolf_arb_pkg`:
  - FSM state typedefs `wr_state_t` and `rd_state_t`.
  - Grant encoding constants `GNT_M0=0`, `GNT_M1=1`.
- Sub-module `swervolf_rr_arb2`: a two-requester round-robin picker with inputs `req[1:0]`, `last`, `en` and outputs `gnt`, `valid`. It is instantiated once for the write channel and once for the read channel.

## Test plan
- Single read: m0 AR addr 0x100, len 3 → slave `arvalid` one cycle after request; 4 R beats reach m0 only; m1 `rvalid` stays 0.
- Simultaneous AW from both masters after reset → m0 served first, then m1. Next simultaneous pair → m1 first.
- m1 asserts W before its AW grant → `o_m1_wready=0` until `W_DATA`. Its 8-beat burst with wstrb 0xFF is written intact; readback matches.
- Concurrent m0 read (len 7) and m1 write (len 0) → both complete with no mutual stall; the B response arrives at m1 before m0's `rlast`.
- Back-pressure: m0 holds `rready=0` for 5 cycles mid-burst → slave sees `rready=0`; no beat is lost or duplicated.
- `rst` asserted mid-write burst → all outputs 0 asynchronously; after release a fresh m1 write completes normally.

Source files
------------

// File: rtl/swervolf_arb_pkg.sv
// Shared types and constants for the SweRVolf two-master RAM arbiter.
// Grant encoding doubles as the last-grant value held per channel.
package swervolf_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/swervolf_rr_arb2.sv
// Two-requester round-robin picker: on a tie the master not granted last
// wins, a lone requester always wins. Purely combinational.
module swervolf_rr_arb2
    import swervolf_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = en & (|req);
        gnt   = GNT_M0;
        if (req == 2'b11) begin
            gnt = (last == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (req[1]) begin
            gnt = GNT_M1;
        end
    end

endmodule

// File: rtl/swervolf_ram_arbiter.sv
// Two-master AXI4 arbiter in front of the SweRVolf on-chip RAM. Read and write
// channels are arbitrated independently, one outstanding transaction each.
module swervolf_ram_arbiter
    import swervolf_arb_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ID_WIDTH-1:0]   i_m0_awid,
    input  logic [ADDR_WIDTH-1:0] i_m0_awaddr,
    input  logic [7:0]            i_m0_awlen,
    input  logic [2:0]            i_m0_awsize,
    input  logic [1:0]            i_m0_awburst,
    input  logic                  i_m0_awvalid,
    output logic                  o_m0_awready,
    input  logic [63:0]           i_m0_wdata,
    input  logic [7:0]            i_m0_wstrb,
    input  logic                  i_m0_wlast,
    input  logic                  i_m0_wvalid,
    output logic                  o_m0_wready,
    output logic [ID_WIDTH-1:0]   o_m0_bid,
    output logic [1:0]            o_m0_bresp,
    output logic                  o_m0_bvalid,
    input  logic                  i_m0_bready,
    input  logic [ID_WIDTH-1:0]   i_m0_arid,
    input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
    input  logic [7:0]            i_m0_arlen,
    input  logic [2:0]            i_m0_arsize,
    input  logic [1:0]            i_m0_arburst,
    input  logic                  i_m0_arvalid,
    output logic                  o_m0_arready,
    output logic [ID_WIDTH-1:0]   o_m0_rid,
    output logic [63:0]           o_m0_rdata,
    output logic [1:0]            o_m0_rresp,
    output logic                  o_m0_rlast,
    output logic                  o_m0_rvalid,
    input  logic                  i_m0_rready,

    input  logic [ID_WIDTH-1:0]   i_m1_awid,
    input  logic [ADDR_WIDTH-1:0] i_m1_awaddr,
    input  logic [7:0]            i_m1_awlen,
    input  logic [2:0]            i_m1_awsize,
    input  logic [1:0]            i_m1_awburst,
    input  logic                  i_m1_awvalid,
    output logic                  o_m1_awready,
    input  logic [63:0]           i_m1_wdata,
    input  logic [7:0]            i_m1_wstrb,
    input  logic                  i_m1_wlast,
    input  logic                  i_m1_wvalid,
    output logic                  o_m1_wready,
    output logic [ID_WIDTH-1:0]   o_m1_bid,
    output logic [1:0]            o_m1_bresp,
    output logic                  o_m1_bvalid,
    input  logic                  i_m1_bready,
    input  logic [ID_WIDTH-1:0]   i_m1_arid,
    input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
    input  logic [7:0]            i_m1_arlen,
    input  logic [2:0]            i_m1_arsize,
    input  logic [1:0]            i_m1_arburst,
    input  logic                  i_m1_arvalid,
    output logic                  o_m1_arready,
    output logic [ID_WIDTH-1:0]   o_m1_rid,
    output logic [63:0]           o_m1_rdata,
    output logic [1:0]            o_m1_rresp,
    output logic                  o_m1_rlast,
    output logic                  o_m1_rvalid,
    input  logic                  i_m1_rready,

    output logic [ID_WIDTH-1:0]   o_s_awid,
    output logic [ADDR_WIDTH-1:0] o_s_awaddr,
    output logic [7:0]            o_s_awlen,
    output logic [2:0]            o_s_awsize,
    output logic [1:0]            o_s_awburst,
    output logic                  o_s_awvalid,
    input  logic                  i_s_awready,
    output logic [63:0]           o_s_wdata,
    output logic [7:0]            o_s_wstrb,
    output logic                  o_s_wlast,
    output logic                  o_s_wvalid,
    input  logic                  i_s_wready,
    input  logic [ID_WIDTH-1:0]   i_s_bid,
    input  logic [1:0]            i_s_bresp,
    input  logic                  i_s_bvalid,
    output logic                  o_s_bready,
    output logic [ID_WIDTH-1:0]   o_s_arid,
    output logic [ADDR_WIDTH-1:0] o_s_araddr,
    output logic [7:0]            o_s_arlen,
    output logic [2:0]            o_s_arsize,
    output logic [1:0]            o_s_arburst,
    output logic                  o_s_arvalid,
    input  logic                  i_s_arready,
    input  logic [ID_WIDTH-1:0]   i_s_rid,
    input  logic [63:0]           i_s_rdata,
    input  logic [1:0]            i_s_rresp,
    input  logic                  i_s_rlast,
    input  logic                  i_s_rvalid,
    output logic                  o_s_rready
);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic      w_gnt, r_gnt;
    logic      w_pick, w_pick_gnt;
    logic      r_pick, r_pick_gnt;

    logic      sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic      sel_arvalid, sel_rready;

    // Arbitration only looks at raw valids in IDLE; the winner is registered,
    // so no valid->ready path ever runs through the picker.
    swervolf_rr_arb2 u_w_arb (
        .req   ({i_m1_awvalid, i_m0_awvalid}),
        .last  (w_gnt),
        .en    (w_state == W_IDLE),
        .gnt   (w_pick_gnt),
        .valid (w_pick)
    );

    swervolf_rr_arb2 u_r_arb (
        .req   ({i_m1_arvalid, i_m0_arvalid}),
        .last  (r_gnt),
        .en    (r_state == R_IDLE),
        .gnt   (r_pick_gnt),
        .valid (r_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            w_gnt   <= GNT_M1;
            r_gnt   <= GNT_M1;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            if (w_pick) w_gnt <= w_pick_gnt;
            if (r_pick) r_gnt <= r_pick_gnt;
        end
    end

    assign sel_awvalid = (w_gnt == GNT_M1) ? i_m1_awvalid : i_m0_awvalid;
    assign sel_wvalid  = (w_gnt == GNT_M1) ? i_m1_wvalid  : i_m0_wvalid;
    assign sel_wlast   = (w_gnt == GNT_M1) ? i_m1_wlast   : i_m0_wlast;
    assign sel_bready  = (w_gnt == GNT_M1) ? i_m1_bready  : i_m0_bready;
    assign sel_arvalid = (r_gnt == GNT_M1) ? i_m1_arvalid : i_m0_arvalid;
    assign sel_rready  = (r_gnt == GNT_M1) ? i_m1_rready  : i_m0_rready;

    // Payloads follow the registered grant unconditionally; only the
    // handshake signals are gated by FSM state.
    assign o_s_awid    = (w_gnt == GNT_M1) ? i_m1_awid    : i_m0_awid;
    assign o_s_awaddr  = (w_gnt == GNT_M1) ? i_m1_awaddr  : i_m0_awaddr;
    assign o_s_awlen   = (w_gnt == GNT_M1) ? i_m1_awlen   : i_m0_awlen;
    assign o_s_awsize  = (w_gnt == GNT_M1) ? i_m1_awsize  : i_m0_awsize;
    assign o_s_awburst = (w_gnt == GNT_M1) ? i_m1_awburst : i_m0_awburst;
    assign o_s_wdata   = (w_gnt == GNT_M1) ? i_m1_wdata   : i_m0_wdata;
    assign o_s_wstrb   = (w_gnt == GNT_M1) ? i_m1_wstrb   : i_m0_wstrb;
    assign o_s_wlast   = sel_wlast;
    assign o_s_arid    = (r_gnt == GNT_M1) ? i_m1_arid    : i_m0_arid;
    assign o_s_araddr  = (r_gnt == GNT_M1) ? i_m1_araddr  : i_m0_araddr;
    assign o_s_arlen   = (r_gnt == GNT_M1) ? i_m1_arlen   : i_m0_arlen;
    assign o_s_arsize  = (r_gnt == GNT_M1) ? i_m1_arsize  : i_m0_arsize;
    assign o_s_arburst = (r_gnt == GNT_M1) ? i_m1_arburst : i_m0_arburst;

    assign o_m0_bid    = i_s_bid;
    assign o_m0_bresp  = i_s_bresp;
    assign o_m1_bid    = i_s_bid;
    assign o_m1_bresp  = i_s_bresp;
    assign o_m0_rid    = i_s_rid;
    assign o_m0_rdata  = i_s_rdata;
    assign o_m0_rresp  = i_s_rresp;
    assign o_m0_rlast  = i_s_rlast;
    assign o_m1_rid    = i_s_rid;
    assign o_m1_rdata  = i_s_rdata;
    assign o_m1_rresp  = i_s_rresp;
    assign o_m1_rlast  = i_s_rlast;

    always_comb begin
        w_next       = w_state;
        o_s_awvalid  = 1'b0;
        o_s_wvalid   = 1'b0;
        o_s_bready   = 1'b0;
        o_m0_awready = 1'b0;
        o_m1_awready = 1'b0;
        o_m0_wready  = 1'b0;
        o_m1_wready  = 1'b0;
        o_m0_bvalid  = 1'b0;
        o_m1_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (w_pick) w_next = W_ADDR;
            end
            W_ADDR: begin
                o_s_awvalid = sel_awvalid;
                if (w_gnt == GNT_M1) o_m1_awready = i_s_awready;
                else                 o_m0_awready = i_s_awready;
                if (sel_awvalid && i_s_awready) w_next = W_DATA;
            end
            W_DATA: begin
                o_s_wvalid = sel_wvalid;
                if (w_gnt == GNT_M1) o_m1_wready = i_s_wready;
                else                 o_m0_wready = i_s_wready;
                if (sel_wvalid && i_s_wready && sel_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                o_s_bready = sel_bready;
                if (w_gnt == GNT_M1) o_m1_bvalid = i_s_bvalid;
                else                 o_m0_bvalid = i_s_bvalid;
                if (i_s_bvalid && sel_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next       = r_state;
        o_s_arvalid  = 1'b0;
        o_s_rready   = 1'b0;
        o_m0_arready = 1'b0;
        o_m1_arready = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m1_rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (r_pick) r_next = R_ADDR;
            end
            R_ADDR: begin
                o_s_arvalid = sel_arvalid;
                if (r_gnt == GNT_M1) o_m1_arready = i_s_arready;
                else                 o_m0_arready = i_s_arready;
                if (sel_arvalid && i_s_arready) r_next = R_DATA;
            end
            R_DATA: begin
                o_s_rready = sel_rready;
                if (r_gnt == GNT_M1) o_m1_rvalid = i_s_rvalid;
                else                 o_m0_rvalid = i_s_rvalid;
                if (i_s_rvalid && sel_rready && i_s_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_swervolf_ram_arbiter.sv
// Self-checking bench: two scripted AXI masters, a behavioural RAM slave and
// an expected-memory reference that every read beat is compared against.
module tb_swervolf_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  m_awid [2];
    logic [31:0] m_awaddr [2];
    logic [7:0]  m_awlen [2];
    logic [2:0]  m_awsize [2];
    logic [1:0]  m_awburst [2];
    logic        m_awvalid [2];
    logic        m_awready [2];
    logic [63:0] m_wdata [2];
    logic [7:0]  m_wstrb [2];
    logic        m_wlast [2];
    logic        m_wvalid [2];
    logic        m_wready [2];
    logic [3:0]  m_bid [2];
    logic [1:0]  m_bresp [2];
    logic        m_bvalid [2];
    logic        m_bready [2];
    logic [3:0]  m_arid [2];
    logic [31:0] m_araddr [2];
    logic [7:0]  m_arlen [2];
    logic [2:0]  m_arsize [2];
    logic [1:0]  m_arburst [2];
    logic        m_arvalid [2];
    logic        m_arready [2];
    logic [3:0]  m_rid [2];
    logic [63:0] m_rdata [2];
    logic [1:0]  m_rresp [2];
    logic        m_rlast [2];
    logic        m_rvalid [2];
    logic        m_rready [2];

    logic [3:0]  s_awid, s_arid, s_bid, s_rid;
    logic [31:0] s_awaddr, s_araddr;
    logic [7:0]  s_awlen, s_arlen, s_wstrb;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rlast, s_rvalid, s_rready;
    logic [63:0] s_wdata, s_rdata;

    swervolf_ram_arbiter #(.ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_m0_awid(m_awid[0]), .i_m0_awaddr(m_awaddr[0]), .i_m0_awlen(m_awlen[0]),
        .i_m0_awsize(m_awsize[0]), .i_m0_awburst(m_awburst[0]), .i_m0_awvalid(m_awvalid[0]),
        .o_m0_awready(m_awready[0]), .i_m0_wdata(m_wdata[0]), .i_m0_wstrb(m_wstrb[0]),
        .i_m0_wlast(m_wlast[0]), .i_m0_wvalid(m_wvalid[0]), .o_m0_wready(m_wready[0]),
        .o_m0_bid(m_bid[0]), .o_m0_bresp(m_bresp[0]), .o_m0_bvalid(m_bvalid[0]),
        .i_m0_bready(m_bready[0]), .i_m0_arid(m_arid[0]), .i_m0_araddr(m_araddr[0]),
        .i_m0_arlen(m_arlen[0]), .i_m0_arsize(m_arsize[0]), .i_m0_arburst(m_arburst[0]),
        .i_m0_arvalid(m_arvalid[0]), .o_m0_arready(m_arready[0]), .o_m0_rid(m_rid[0]),
        .o_m0_rdata(m_rdata[0]), .o_m0_rresp(m_rresp[0]), .o_m0_rlast(m_rlast[0]),
        .o_m0_rvalid(m_rvalid[0]), .i_m0_rready(m_rready[0]),
        .i_m1_awid(m_awid[1]), .i_m1_awaddr(m_awaddr[1]), .i_m1_awlen(m_awlen[1]),
        .i_m1_awsize(m_awsize[1]), .i_m1_awburst(m_awburst[1]), .i_m1_awvalid(m_awvalid[1]),
        .o_m1_awready(m_awready[1]), .i_m1_wdata(m_wdata[1]), .i_m1_wstrb(m_wstrb[1]),
        .i_m1_wlast(m_wlast[1]), .i_m1_wvalid(m_wvalid[1]), .o_m1_wready(m_wready[1]),
        .o_m1_bid(m_bid[1]), .o_m1_bresp(m_bresp[1]), .o_m1_bvalid(m_bvalid[1]),
        .i_m1_bready(m_bready[1]), .i_m1_arid(m_arid[1]), .i_m1_araddr(m_araddr[1]),
        .i_m1_arlen(m_arlen[1]), .i_m1_arsize(m_arsize[1]), .i_m1_arburst(m_arburst[1]),
        .i_m1_arvalid(m_arvalid[1]), .o_m1_arready(m_arready[1]), .o_m1_rid(m_rid[1]),
        .o_m1_rdata(m_rdata[1]), .o_m1_rresp(m_rresp[1]), .o_m1_rlast(m_rlast[1]),
        .o_m1_rvalid(m_rvalid[1]), .i_m1_rready(m_rready[1]),
        .o_s_awid(s_awid), .o_s_awaddr(s_awaddr), .o_s_awlen(s_awlen), .o_s_awsize(s_awsize),
        .o_s_awburst(s_awburst), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast), .o_s_wvalid(s_wvalid),
        .i_s_wready(s_wready), .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid),
        .o_s_bready(s_bready), .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen),
        .o_s_arsize(s_arsize), .o_s_arburst(s_arburst), .o_s_arvalid(s_arvalid),
        .i_s_arready(s_arready), .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
        .i_s_rlast(s_rlast), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready)
    );

    // Behavioural RAM slave with optional random back-pressure; shares rst.
    logic [63:0] mem [256];
    logic [1:0]  sw_st;
    logic        sr_st;
    logic [7:0]  w_idx, r_idx, r_len, r_beat;
    logic [3:0]  w_id, r_id, rnd;
    logic        stall_en = 1'b0;

    assign s_awready = (sw_st == 2'd0) && rnd[0];
    assign s_wready  = (sw_st == 2'd1) && rnd[1];
    assign s_bid     = w_id;
    assign s_bresp   = 2'b00;
    assign s_arready = !sr_st && rnd[2];
    assign s_rdata   = mem[8'(r_idx + r_beat)];
    assign s_rid     = r_id;
    assign s_rresp   = 2'b00;
    assign s_rlast   = (r_beat == r_len);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_st    <= 2'd0;
            sr_st    <= 1'b0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            rnd      <= 4'hF;
            w_idx    <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            w_id     <= '0;
            r_id     <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            rnd <= stall_en ? 4'($urandom) : 4'hF;
            case (sw_st)
                2'd0: if (s_awvalid && s_awready) begin
                    w_idx <= s_awaddr[10:3];
                    w_id  <= s_awid;
                    sw_st <= 2'd1;
                end
                2'd1: if (s_wvalid && s_wready) begin
                    for (int k = 0; k < 8; k++)
                        if (s_wstrb[k]) mem[w_idx][8*k +: 8] <= s_wdata[8*k +: 8];
                    w_idx <= w_idx + 8'd1;
                    if (s_wlast) begin
                        sw_st    <= 2'd2;
                        s_bvalid <= 1'b1;
                    end
                end
                default: if (s_bvalid && s_bready) begin
                    s_bvalid <= 1'b0;
                    sw_st    <= 2'd0;
                end
            endcase
            if (!sr_st) begin
                if (s_arvalid && s_arready) begin
                    r_idx    <= s_araddr[10:3];
                    r_len    <= s_arlen;
                    r_beat   <= 8'd0;
                    r_id     <= s_arid;
                    sr_st    <= 1'b1;
                    s_rvalid <= 1'b0;
                end
            end else if (s_rvalid && s_rready) begin
                if (s_rlast) begin
                    sr_st    <= 1'b0;
                    s_rvalid <= 1'b0;
                end else begin
                    r_beat   <= r_beat + 8'd1;
                    s_rvalid <= rnd[3];
                end
            end else if (!s_rvalid) begin
                s_rvalid <= rnd[3];
            end
        end
    end

    logic [3:0] aw_order [$];
    always @(posedge clk) if (s_awvalid && s_awready) aw_order.push_back(s_awid);

    logic [14:0] hs_outs;
    assign hs_outs = {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
                      m_awready[0], m_awready[1], m_wready[0], m_wready[1],
                      m_arready[0], m_arready[1], m_bvalid[0], m_bvalid[1],
                      m_rvalid[0], m_rvalid[1]};

    logic [63:0] exp_mem [256];
    longint      bhs_time [2];
    longint      rlast_time [2];
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic masterWrite(input int m, input logic [3:0] id, input int base, input int len,
                               input bit early_w, input bit rand_strb);
        logic [63:0] data [$];
        logic [7:0]  strb [$];
        bit hs;
        int accepted;
        for (int b = 0; b <= len; b++) begin
            data.push_back({$urandom, $urandom});
            strb.push_back(rand_strb ? 8'($urandom) : 8'hFF);
        end
        if (early_w) begin
            m_wdata[m] = data[0]; m_wstrb[m] = strb[0]; m_wlast[m] = (len == 0); m_wvalid[m] = 1'b1;
            repeat (3) begin
                @(negedge clk);
                checkOutput($sformatf("m%0d_wready_before_aw", m), 64'(m_wready[m]), 64'd0);
                @(posedge clk); #1;
            end
        end
        m_awid[m] = id; m_awaddr[m] = 32'(base * 8); m_awlen[m] = 8'(len);
        m_awsize[m] = 3'd3; m_awburst[m] = 2'd1; m_awvalid[m] = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = m_awready[m];
            if (early_w) checkOutput($sformatf("m%0d_wready_in_aw", m), 64'(m_wready[m]), 64'd0);
            @(posedge clk); #1;
        end
        m_awvalid[m] = 1'b0;
        checkOutput($sformatf("m%0d_aw_handshake", m), 64'(hs), 64'd1);
        accepted = 0;
        for (int b = 0; b <= len; b++) begin
            m_wdata[m] = data[b]; m_wstrb[m] = strb[b]; m_wlast[m] = (b == len); m_wvalid[m] = 1'b1;
            hs = 1'b0;
            for (int c = 0; c < 200 && !hs; c++) begin
                @(negedge clk);
                hs = m_wready[m];
                @(posedge clk); #1;
            end
            if (hs) accepted++;
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
        checkOutput($sformatf("m%0d_w_beats", m), 64'(accepted), 64'(len + 1));
        m_bready[m] = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            if (m_bvalid[m]) begin
                hs = 1'b1;
                bhs_time[m] = $time;
                checkOutput($sformatf("m%0d_bid", m), 64'(m_bid[m]), 64'(id));
                checkOutput($sformatf("m%0d_bresp", m), 64'(m_bresp[m]), 64'd0);
            end
            @(posedge clk); #1;
        end
        m_bready[m] = 1'b0;
        checkOutput($sformatf("m%0d_b_handshake", m), 64'(hs), 64'd1);
        for (int b = 0; b <= len; b++)
            for (int k = 0; k < 8; k++)
                if (strb[b][k]) exp_mem[(base + b) % 256][8*k +: 8] = data[b][8*k +: 8];
    endtask

    task automatic masterRead(input int m, input logic [3:0] id, input int base, input int len,
                              input int stall_beat, input int stall_cycles);
        int  beat = 0;
        int  stall_left;
        bit  hs = 1'b0;
        bit  done = 1'b0;
        stall_left = stall_cycles;
        m_arid[m] = id; m_araddr[m] = 32'(base * 8); m_arlen[m] = 8'(len);
        m_arsize[m] = 3'd3; m_arburst[m] = 2'd1; m_arvalid[m] = 1'b1;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = m_arready[m];
            @(posedge clk); #1;
        end
        m_arvalid[m] = 1'b0;
        checkOutput($sformatf("m%0d_ar_handshake", m), 64'(hs), 64'd1);
        m_rready[m] = !(beat == stall_beat && stall_left > 0);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (m_rvalid[m] && m_rready[m]) begin
                checkOutput($sformatf("m%0d_rdata_b%0d", m, beat), m_rdata[m], exp_mem[(base + beat) % 256]);
                checkOutput($sformatf("m%0d_rid", m), 64'(m_rid[m]), 64'(id));
                checkOutput($sformatf("m%0d_rlast_b%0d", m, beat), 64'(m_rlast[m]), 64'(beat == len));
                checkOutput($sformatf("m%0d_rresp", m), 64'(m_rresp[m]), 64'd0);
                if (beat == len) begin
                    done = 1'b1;
                    rlast_time[m] = $time;
                end
                beat++;
            end else if (!m_rready[m]) begin
                checkOutput($sformatf("m%0d_s_rready_held", m), 64'(s_rready), 64'd0);
                stall_left--;
            end
            @(posedge clk); #1;
            m_rready[m] = !done && !(beat == stall_beat && stall_left > 0);
        end
        m_rready[m] = 1'b0;
        checkOutput($sformatf("m%0d_r_beats", m), 64'(beat), 64'(len + 1));
    endtask

    // One random transaction per master, confined to that master's half of RAM.
    task automatic applyStimulus(input int m);
        int len;
        int base;
        logic [3:0] id;
        len  = int'($urandom_range(0, 7));
        base = m * 128 + int'($urandom_range(0, 127 - len));
        id   = 4'($urandom);
        if ($urandom_range(0, 1) == 1) masterWrite(m, id, base, len, 1'b0, 1'b1);
        else                           masterRead(m, id, base, len, -1, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int  n0;
        int  wr_last;
        int  exp_first;
        int  m1_rvalid_seen;
        logic [3:0] ids [2];
        ids[0] = 4'h3;
        ids[1] = 4'hC;
        for (int m = 0; m < 2; m++) begin
            m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = 3'd3; m_awburst[m] = 2'd1;
            m_awvalid[m] = 1'b0; m_wdata[m] = '0; m_wstrb[m] = '0; m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0;
            m_bready[m] = 1'b0; m_arid[m] = '0; m_araddr[m] = '0; m_arlen[m] = '0; m_arsize[m] = 3'd3;
            m_arburst[m] = 2'd1; m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
            bhs_time[m] = 0; rlast_time[m] = 0;
        end
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_handshake_outputs", 64'(hs_outs), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_handshake_outputs", 64'(hs_outs), 64'd0);
        wr_last = 1;

        // Simultaneous AW pair, a solo m0 write, then another pair
        for (int pass = 0; pass < 3; pass++) begin
            n0 = aw_order.size();
            if (pass == 1) begin
                masterWrite(0, ids[0], 40, 1, 1'b0, 1'b0);
                wr_last = 0;
                checkOutput("solo_m0_aw_id", 64'(aw_order[n0]), 64'(ids[0]));
            end else begin
                exp_first = (wr_last == 1) ? 0 : 1;
                fork
                    masterWrite(0, ids[0], (pass == 0) ? 32 : 48, (pass == 0) ? 3 : 2, 1'b0, 1'b0);
                    masterWrite(1, ids[1], (pass == 0) ? 160 : 170, (pass == 0) ? 3 : 2, 1'b0, 1'b0);
                join
                checkOutput($sformatf("pair%0d_aw_count", pass), 64'(aw_order.size() - n0), 64'd2);
                checkOutput($sformatf("pair%0d_first", pass), 64'(aw_order[n0]), 64'(ids[exp_first]));
                checkOutput($sformatf("pair%0d_second", pass), 64'(aw_order[n0 + 1]), 64'(ids[1 - exp_first]));
                wr_last = 1 - exp_first;
            end
        end

        // Single m0 read of 0x100, len 3: one-cycle arbitration latency, m1 stays quiet
        m1_rvalid_seen = 0;
        fork
            masterRead(0, 4'h5, 32, 3, -1, 0);
            begin
                @(negedge clk);
                checkOutput("arvalid_request_cycle", 64'(s_arvalid), 64'd0);
                @(negedge clk);
                checkOutput("arvalid_next_cycle", 64'(s_arvalid), 64'd1);
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (m_rvalid[1]) m1_rvalid_seen++;
                end
            end
        join
        checkOutput("m1_rvalid_during_m0_read", 64'(m1_rvalid_seen), 64'd0);

        // m1 presents W before AW, 8 beats full strobe, then reads it back
        stall_en = 1'b1;
        masterWrite(1, 4'h9, 136, 7, 1'b1, 1'b0);
        masterRead(1, 4'h9, 136, 7, -1, 0);

        // Concurrent m0 read and m1 write on an unstalled slave
        stall_en = 1'b0;
        fork
            masterRead(0, 4'h1, 32, 7, -1, 0);
            masterWrite(1, 4'h7, 180, 0, 1'b0, 1'b0);
        join
        checkOutput("b_before_rlast", 64'(bhs_time[1] < rlast_time[0]), 64'd1);

        // m0 back-pressure: rready low for 5 cycles at beat 2
        masterRead(0, 4'h2, 160, 7, 2, 5);

        // Randomized traffic from both masters with slave stalls
        stall_en = 1'b1;
        for (int it = 0; it < 16; it++) begin
            fork
                applyStimulus(0);
                applyStimulus(1);
            join
        end

        // Reset in the middle of an m1 write burst
        stall_en = 1'b0;
        m_awid[1] = 4'h5; m_awaddr[1] = 32'(200 * 8); m_awlen[1] = 8'd7; m_awvalid[1] = 1'b1;
        begin
            bit hs = 1'b0;
            for (int c = 0; c < 200 && !hs; c++) begin
                @(negedge clk);
                hs = m_awready[1];
                @(posedge clk); #1;
            end
            checkOutput("abort_aw_handshake", 64'(hs), 64'd1);
        end
        m_awvalid[1] = 1'b0;
        m_wdata[1] = {$urandom, $urandom}; m_wstrb[1] = 8'hFF; m_wlast[1] = 1'b0; m_wvalid[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("mid_burst_wvalid", 64'(s_wvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", 64'(hs_outs), 64'd0);
        m_wvalid[1] = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        masterWrite(1, 4'h6, 200, 7, 1'b0, 1'b0);
        masterRead(1, 4'h6, 200, 7, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
